serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one `full_adder` instance (ports A, B, Cin, S, Cout) over WIDTH clock cycles to add two WIDTH-bit operands.
- Processing is LSB first. A carry flip-flop feeds Cout back into Cin on each bit.
- Sits between a requester using a start/done handshake and the shared 1-bit adder datapath. It trades latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a_in, input, WIDTH, operand A; captured on the accepting edge.
- b_in, input, WIDTH, operand B; captured on the accepting edge.
- cin, input, 1, initial carry-in; captured on the accepting edge.
- busy, output, 1, high while bits are being processed (RUN).
- done, output, 1, one-cycle pulse; result valid.
- sum_out, output, WIDTH, registered sum; held until the next completion.
- cout, output, 1, registered final carry-out; held alongside sum_out.

Behaviour:
- Reset: rst_n low forces, immediately and regardless of clk:
  - state=IDLE, busy=0, done=0, sum_out=0, cout=0;
  - internal operand/shift registers=0, carry flop=0, bit counter=0.
- Reset mid-operation aborts the addition. No done is produced and no partial result becomes visible.
- States: IDLE, RUN, FINISH. All outputs are registered (no combinational path from inputs to outputs).
- IDLE:
  - On an edge with start=1: load a_in→a_sh, b_in→b_sh, cin→carry, clear sum_sh, count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, per edge:
  - Drive the adder with A=a_sh[0], B=b_sh[0], Cin=carry.
  - Shift a_sh and b_sh right by 1.
  - Shift S into sum_sh at the MSB (right shift), so bit 0 ends at LSB after WIDTH shifts.
  - carry<=Cout; count<=count+1.
  - On the edge where count==WIDTH-1: copy the final sum_sh into sum_out, copy Cout into cout, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE unconditionally.
- start during RUN or FINISH is ignored. There is no queuing.
- Outputs by state:
  - busy=1 exactly in RUN;
  - done=1 exactly in FINISH;
  - busy and done are never high together.
- Latency: start accepted at edge E0; busy high from E0 to EWIDTH; done high from EWIDTH to EWIDTH+1.
- Throughput with start held high: one operation per WIDTH+2 cycles.
- a_in, b_in and cin changing after E0 have no effect on the operation in flight.
- sum_out and cout change only on the RUN→FINISH edge (or on reset). They stay stable through IDLE and through the next RUN.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1). This is exact; no overflow flag beyond cout.
- Counter width is clog2(WIDTH+1). WIDTH=1 gives RUN lasting one cycle.

Test Plan:
- WIDTH=8, start pulse with a=0x0F, b=0x01, cin=0 → busy high 8 cycles; done pulses 1 cycle at E8; sum_out=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout=1; results hold after done falls.
- start held high, operands changed every cycle → one done every 10 cycles. Each result matches the operands present on its accepting edge; mid-run operand changes and start are ignored.
- rst_n pulsed low asynchronously (mid-cycle) after 4 RUN cycles of 0xAA+0x55 → outputs 0 immediately, state IDLE, no done. A subsequent 0x12+0x34 → sum_out=0x46, cout=0.
- WIDTH=2 and WIDTH=1 builds, all 2^(2W+1) operand/cin combinations → every {cout,sum_out} equals a+b+cin; done latency = WIDTH cycles after accept.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/done request bus between a requester and the serial adder controller
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    modport master (output start, a_in, b_in, cin, input busy, done, sum_out, cout);
    modport slave (input start, a_in, b_in, cin, output busy, done, sum_out, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands LSB first through a single full_adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [WIDTH:0]   sh_nx;
    logic [CW-1:0]    count;
    logic             carry, s, co, last;
    full_adder u_fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .S(s), .Cout(co));
    always_comb begin
        last     = count == CW'(WIDTH - 1);
        sh_nx    = {s, sum_sh};
        sum_nx   = sh_nx[WIDTH:1];
        state_nx = (state == IDLE) ? (bus.start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? FINISH : RUN) : IDLE;
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == FINISH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry       <= 1'b0;
            count       <= '0;
            bus.sum_out <= '0;
            bus.cout    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                a_sh   <= bus.a_in;
                b_sh   <= bus.b_in;
                carry  <= bus.cin;
                sum_sh <= '0;
                count  <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= sum_nx;
                carry  <= co;
                count  <= count + CW'(1);
                // results become visible only once the last bit is in
                if (last) begin
                    bus.sum_out <= sum_nx;
                    bus.cout    <= co;
                end
            end
        end
    end
endmodule

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and exhaustive checks of the serial adder at WIDTH 8, 2 and 1
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    always #5 clk = ~clk;
    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(2)) if2 ();
    serial_add_ctrl_if #(.WIDTH(1)) if1 ();
    serial_add_ctrl #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_add_ctrl #(.WIDTH(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    serial_add_ctrl #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one WIDTH=8 operation; start and operands are scrambled while in flight
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] exp, prev;
        exp  = 9'(a) + 9'(b) + 9'(c);
        prev = {if8.cout, if8.sum_out};
        if8.start = 1'b1; if8.a_in = a; if8.b_in = b; if8.cin = c;
        @(posedge clk); #1;
        if8.start = 1'b0;
        chk("busy_e0", {if8.busy, if8.done}, 2'b10);
        for (int k = 1; k < 8; k++) begin
            if8.start = 1'($urandom); if8.a_in = 8'($urandom); if8.b_in = 8'($urandom); if8.cin = 1'($urandom);
            @(posedge clk); #1;
            chk("busy_run", {if8.busy, if8.done}, 2'b10);
            chk("hold_run", {if8.cout, if8.sum_out}, prev);
        end
        @(posedge clk); #1;
        chk("done_e8", {if8.busy, if8.done}, 2'b01);
        chk("result8", {if8.cout, if8.sum_out}, exp);
        @(posedge clk); #1;
        if8.start = 1'b0;
        chk("done_fall", {if8.busy, if8.done}, 2'b00);
        chk("hold_idle", {if8.cout, if8.sum_out}, exp);
    endtask

    initial begin
        logic [16:0] ops [40];
        logic [4:0]  v;
        if8.start = 0; if8.a_in = 0; if8.b_in = 0; if8.cin = 0;
        if2.start = 0; if2.a_in = 0; if2.b_in = 0; if2.cin = 0;
        if1.start = 0; if1.a_in = 0; if1.b_in = 0; if1.cin = 0;
        #2;
        chk("reset_out", {if8.busy, if8.done, if8.cout, if8.sum_out}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run8(8'h0F, 8'h01, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 6; i++) run8(8'($urandom), 8'($urandom), 1'($urandom));
        // start held high: accepts every 10 edges, result from operands at the accepting edge
        for (int i = 0; i < 40; i++) begin
            if8.start = 1'b1; if8.a_in = 8'($urandom); if8.b_in = 8'($urandom); if8.cin = 1'($urandom);
            ops[i] = 17'(if8.a_in) + 17'(if8.b_in) + 17'(if8.cin);
            @(posedge clk); #1;
            chk("hh_done", if8.done, 32'(i % 10 == 8));
            if (i % 10 == 8) chk("hh_result", {if8.cout, if8.sum_out}, 32'(ops[i-8]));
        end
        if8.start = 1'b0;
        @(posedge clk); #1;
        run8(8'hFF, 8'hFF, 1'b1);
        // asynchronous reset four RUN cycles into an addition
        if8.start = 1'b1; if8.a_in = 8'hAA; if8.b_in = 8'h55; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_rst", {if8.busy, if8.done, if8.cout, if8.sum_out}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("no_done", {if8.busy, if8.done, if8.cout, if8.sum_out}, 0);
        end
        run8(8'h12, 8'h34, 1'b0);
        // exhaustive WIDTH=2
        for (int x = 0; x < 32; x++) begin
            v = 5'(x);
            if2.start = 1'b1; if2.a_in = v[1:0]; if2.b_in = v[3:2]; if2.cin = v[4];
            @(posedge clk); #1;
            if2.start = 1'b0;
            chk("w2_busy", {if2.busy, if2.done}, 2'b10);
            @(posedge clk); #1;
            chk("w2_busy1", {if2.busy, if2.done}, 2'b10);
            @(posedge clk); #1;
            chk("w2_done", {if2.busy, if2.done}, 2'b01);
            chk("w2_sum", {if2.cout, if2.sum_out}, 32'(v[1:0]) + 32'(v[3:2]) + 32'(v[4]));
            @(posedge clk); #1;
            chk("w2_idle", {if2.busy, if2.done}, 2'b00);
        end
        // exhaustive WIDTH=1
        for (int x = 0; x < 8; x++) begin
            v = 5'(x);
            if1.start = 1'b1; if1.a_in = v[0]; if1.b_in = v[1]; if1.cin = v[2];
            @(posedge clk); #1;
            if1.start = 1'b0;
            chk("w1_busy", {if1.busy, if1.done}, 2'b10);
            @(posedge clk); #1;
            chk("w1_done", {if1.busy, if1.done}, 2'b01);
            chk("w1_sum", {if1.cout, if1.sum_out}, 32'(v[0]) + 32'(v[1]) + 32'(v[2]));
            @(posedge clk); #1;
            chk("w1_idle", {if1.busy, if1.done}, 2'b00);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
